// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: execute-stage hazard controller.
// Produces operand forwarding selects, a single-bubble load-use interlock,
// a hold sequence for multi-cycle EX operations, and a saturating count of
// front-end stall cycles.
//
// Forwarding select encoding on ra_sel / rb_sel:
//   2'd0 FW_SEL_NONE    operand comes from the register file
//   2'd1 FW_SEL_EX_MEM  operand comes from the EX/MEM result
//   2'd2 FW_SEL_MEM_WB  operand comes from the MEM/WB result
module ex_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int EX_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ra_addr,
  input  logic [REG_ADDR_W-1:0] id_rb_addr,
  input  logic                  id_ra_used,
  input  logic                  id_rb_used,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_ra_addr,
  input  logic [REG_ADDR_W-1:0] ex_rb_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_rd_we,
  input  logic                  ex_is_load,
  input  logic                  ex_multicycle,
  input  logic                  mem_valid,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  wb_valid,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  flush,
  output logic [1:0]            ra_sel,
  output logic [1:0]            rb_sel,
  output logic                  stall_front,
  output logic                  bubble_ex,
  output logic                  hold_ex,
  output logic                  ex_last,
  output logic [31:0]           stall_cycles
);

  localparam logic [1:0] FW_SEL_NONE   = 2'd0;
  localparam logic [1:0] FW_SEL_EX_MEM = 2'd1;
  localparam logic [1:0] FW_SEL_MEM_WB = 2'd2;

  // Counter only needs to hold EX_CYCLES-2; keep at least one bit.
  localparam int CNT_W = (EX_CYCLES > 2) ? $clog2(EX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EX_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      stall_cycles_q;

  logic luh;
  logic mc_start;
  logic hold_raw;
  logic last_raw;
  logic kill;

  // Pick the newest in-flight producer of an EX source register; r0 never forwards.
  function automatic logic [1:0] fw_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  m_valid,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  w_valid,
    input logic                  w_we,
    input logic [REG_ADDR_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FW_SEL_NONE;
    if (src != '0) begin
      if (m_valid && m_we && (m_rd == src)) begin
        sel = FW_SEL_EX_MEM;
      end else if (w_valid && w_we && (w_rd == src)) begin
        sel = FW_SEL_MEM_WB;
      end
    end
    return sel;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Operand forwarding selects; forced to NONE while in reset.
  always_comb begin
    ra_sel = FW_SEL_NONE;
    rb_sel = FW_SEL_NONE;
    if (!rst) begin
      ra_sel = fw_sel(ex_ra_addr, mem_valid, mem_rd_we, mem_rd_addr,
                      wb_valid, wb_rd_we, wb_rd_addr);
      rb_sel = fw_sel(ex_rb_addr, mem_valid, mem_rd_we, mem_rd_addr,
                      wb_valid, wb_rd_we, wb_rd_addr);
    end
  end

  // Load-use detect: the load result is only usable from MEM/WB, so a
  // consumer directly behind it in ID must wait one cycle.
  always_comb begin
    luh = ex_valid && ex_is_load && ex_rd_we && (ex_rd_addr != '0) && id_valid &&
          ((id_ra_used && (id_ra_addr == ex_rd_addr)) ||
           (id_rb_used && (id_rb_addr == ex_rd_addr)));
  end

  // Multi-cycle sequencing status; an op is only picked up from IDLE, so the
  // op still in ID/EX during the release cycle cannot start a second run.
  always_comb begin
    mc_start = (state_q == IDLE) && ex_valid && ex_multicycle && !flush;
    hold_raw = mc_start || ((state_q == BUSY) && (cnt_q != '0));
    last_raw = (state_q == BUSY) && (cnt_q == '0);
  end

  // Pipeline controls with priority flush/reset > multi-cycle hold > load-use.
  always_comb begin
    kill        = rst || flush;
    hold_ex     = !kill && hold_raw;
    ex_last     = !kill && last_raw;
    stall_front = !kill && (hold_raw || luh);
    bubble_ex   = !kill && !hold_raw && luh;
  end

  // Multi-cycle FSM: IDLE loads the remaining-hold count, BUSY counts it down.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_start) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the front end is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_front) begin
      stall_cycles_q <= sat_inc(stall_cycles_q);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard controller for the execute stage. It generates the operand forwarding selects consumed by the EX stage. It interlocks load-use hazards with a single bubble and sequences multi-cycle EX operations through a small FSM that holds the front of the pipeline. It also keeps a saturating stall-cycle counter for performance monitoring. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold/bubble controls.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero
- EX_CYCLES, 4, total cycles a multi-cycle op occupies EX; legal range ≥ 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_ra_addr, id_rb_addr  in  REG_ADDR_W  ID source registers
- id_ra_used, id_rb_used  in  1  ID instruction reads that source
- ex_valid  in  1  ID/EX holds a valid instruction
- ex_ra_addr, ex_rb_addr  in  REG_ADDR_W  EX source registers
- ex_rd_addr  in  REG_ADDR_W  EX destination
- ex_rd_we  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_multicycle  in  1  EX instruction needs EX_CYCLES cycles
- mem_valid, mem_rd_we  in  1  EX/MEM valid and write-enable
- mem_rd_addr  in  REG_ADDR_W  EX/MEM destination
- wb_valid, wb_rd_we  in  1  MEM/WB valid and write-enable
- wb_rd_addr  in  REG_ADDR_W  MEM/WB destination
- flush  in  1  redirect/trap; kills ID and EX contents this cycle
- ra_sel, rb_sel  out  fw_sel_e  EX operand source: FW_SEL_NONE, FW_SEL_EX_MEM or FW_SEL_MEM_WB
- stall_front  out  1  hold PC and IF/ID
- bubble_ex  out  1  load ID/EX with a bubble
- hold_ex  out  1  hold ID/EX and load EX/MEM with a bubble
- ex_last  out  1  final cycle of a multi-cycle op; result valid from the EX unit
- stall_cycles  out  32  saturating count of cycles with stall_front high

## Operation
- Forwarding (combinational), evaluated per operand x ∈ {a, b}:
  - FW_SEL_EX_MEM if mem_valid & mem_rd_we & mem_rd_addr == ex_rx_addr & ex_rx_addr ≠ 0.
  - Otherwise FW_SEL_MEM_WB if the same condition holds for wb_*.
  - Otherwise FW_SEL_NONE.
  - EX/MEM has priority because it is the newer value.
- Load-use hazard: luh = ex_valid & ex_is_load & ex_rd_we & ex_rd_addr ≠ 0 & id_valid & ((id_ra_used & id_ra_addr == ex_rd_addr) | (id_rb_used & id_rb_addr == ex_rd_addr)).
  - One bubble suffices: the load then reaches MEM/WB when the consumer is in EX, so loads are never forwarded from EX/MEM.
- FSM states: IDLE, BUSY; 2-bit counter cnt, width $clog2(EX_CYCLES).
  - IDLE: if ex_valid & ex_multicycle & !flush, then hold_ex = 1, cnt ← EX_CYCLES−2, go to BUSY.
  - BUSY, cnt ≠ 0: hold_ex = 1, cnt ← cnt−1.
  - BUSY, cnt == 0: hold_ex = 0, ex_last = 1, go to IDLE.
  - The op still sitting in ID/EX during the release cycle does not retrigger the FSM.
  - Back-to-back multi-cycle ops are each held for the full EX_CYCLES.
- Output priority: flush > hold_ex > luh.
  - flush: state ← IDLE, cnt ← 0; stall_front, bubble_ex, hold_ex and ex_last all 0.
  - hold_ex = 1: stall_front = 1, bubble_ex = 0 (ID/EX is held, not bubbled).
  - luh & !hold_ex: stall_front = 1, bubble_ex = 1.
- stall_cycles increments each cycle stall_front = 1 and saturates at 0xFFFF_FFFF.

## Timing
- Forwarding selects, stall_front, bubble_ex, hold_ex and ex_last are combinational from inputs and state in the same cycle. The FSM, cnt and stall_cycles are registered.
- A multi-cycle op occupies EX for exactly EX_CYCLES cycles: hold_ex is high for the first EX_CYCLES−1, then ex_last is high for one cycle.
- Load-use costs exactly 1 stall cycle.
- Reset values, and required behaviour while rst is high:
  - state IDLE, cnt 0, stall_cycles 0.
  - stall_front, bubble_ex, hold_ex and ex_last forced 0.
  - ra_sel and rb_sel are FW_SEL_NONE.
- Reset asserted mid-BUSY aborts the op; the FSM is in IDLE on the first cycle after rst falls.
- flush arriving in BUSY aborts the op in that same cycle, and no ex_last is produced.

## Test plan
- ex_ra_addr = 3; mem writes r3 and wb writes r3 → ra_sel = FW_SEL_EX_MEM. With only wb writing r3 → FW_SEL_MEM_WB. With ex_ra_addr = 0 and both stages writing r0 → FW_SEL_NONE.
- Load r5 in EX, ID reads r5 via rb → one cycle with stall_front = 1, bubble_ex = 1. The next cycle has no stall, the consumer reaches EX with rb_sel = FW_SEL_MEM_WB, and stall_cycles = 1.
- EX_CYCLES = 4, multicycle op enters EX at cycle t → hold_ex = 1 at t..t+2, ex_last = 1 at t+3, stall_front = 1 at t..t+2.
- Two consecutive multicycle ops → each gets 3 hold cycles plus an ex_last cycle, 8 cycles total, with no gap and no retrigger.
- flush at BUSY cnt = 1 → hold_ex = 0 that cycle, IDLE next cycle, and ex_last never asserts. Repeating the scenario with rst in place of flush gives the same result, and stall_cycles reads 0.
- Force stall_cycles to 0xFFFF_FFFE, then apply 3 stall cycles → it holds at 0xFFFF_FFFF.
